// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: valid/ready event channel between arbiter and consumer
interface button_event_arbiter_if #(parameter int ID_W = 2);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;
  modport master (output evt_valid, evt_id, input evt_ready);
  modport slave  (input evt_valid, evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces push-buttons and hands presses out round-robin
module button_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int DIV    = 5000,
  parameter int STABLE = 4,
  parameter int ID_W   = $clog2(N_BTN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       btn_raw,
  button_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]       pending,
  output logic [N_BTN-1:0]       overrun,
  input  logic                   clr_overrun
);
  localparam int TW = $clog2(DIV);
  localparam int CW = $clog2(STABLE);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t                   state_q;
  logic [N_BTN-1:0]         sync1_q, sync2_q, stable_q, stable_d, diff, flip, press;
  logic [N_BTN-1:0]         pending_q, pending_d, overrun_q, overrun_d, take_mask;
  logic [N_BTN-1:0][CW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0]            tcnt_q;
  logic [ID_W-1:0]          rr_q, gnt, evt_id_q;
  logic                     evt_valid_q, tick, take;
  assign tick     = tcnt_q == TW'(DIV - 1);
  assign diff     = sync2_q ^ stable_q;
  assign stable_d = stable_q ^ flip;
  assign press    = flip & sync2_q;
  // debounce: count consecutive differing samples, flip the level on the STABLE-th
  always_comb begin
    flip   = '0;
    dcnt_d = dcnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      flip[i]   = tick && diff[i] && dcnt_q[i] == CW'(STABLE - 1);
      dcnt_d[i] = !tick ? dcnt_q[i] : (!diff[i] || flip[i]) ? '0 : dcnt_q[i] + CW'(1);
    end
  end
  // round-robin pick: lowest pending index at or above rr, else lowest overall
  always_comb begin
    gnt = '0;
    for (int i = N_BTN - 1; i >= 0; i--) if (pending_q[i]) gnt = ID_W'(i);
    for (int i = N_BTN - 1; i >= 0; i--) if (pending_q[i] && ID_W'(i) >= rr_q) gnt = ID_W'(i);
  end
  assign take      = state_q == IDLE && |pending_q;
  assign take_mask = take ? N_BTN'(1) << gnt : '0;
  assign pending_d = pending_q & ~take_mask | press;
  assign overrun_d = (clr_overrun ? '0 : overrun_q) | press & pending_q & ~take_mask;
  // synchronisers, sample timer, debounce state and pending/overrun flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      tcnt_q    <= '0;
      stable_q  <= '0;
      dcnt_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      tcnt_q    <= tick ? '0 : tcnt_q + TW'(1);
      stable_q  <= stable_d;
      dcnt_q    <= dcnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end
  // grant FSM: present one event, hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_q        <= '0;
    end else if (state_q == IDLE) begin
      if (take) begin
        evt_id_q    <= gnt;
        evt_valid_q <= 1'b1;
        rr_q        <= gnt == ID_W'(N_BTN - 1) ? '0 : gnt + ID_W'(1);
        state_q     <= PRESENT;
      end
    end else if (evt.evt_ready) begin
      evt_valid_q <= 1'b0;
      state_q     <= IDLE;
    end
  end
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign pending       = pending_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: randomized scoreboard bench with a behavioural button model
module tb_button_event_arbiter;
  localparam int N = 4, DIV = 4, STABLE = 3, ID_W = 2;
  logic clk = 0, rst = 0, clr_overrun = 0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] pending, overrun;
  int vectors = 0, errors = 0, n_events = 0;
  button_event_arbiter_if #(.ID_W(ID_W)) evt ();
  button_event_arbiter #(.N_BTN(N), .DIV(DIV), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .evt(evt),
    .pending(pending), .overrun(overrun), .clr_overrun(clr_overrun));
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // reference model: buttons seen two clocks late, sampled every DIV clocks; a level
  // is accepted once the last STABLE samples since the previous change all disagree
  logic [N-1:0] d1, d2, lvl, mp, mo, pre, prs, gm;
  logic [STABLE-1:0] win [N];
  int seen [N];
  int edge_n, rr, cur_id, g;
  bit busy;
  int exp_q [$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 = '0; d2 = '0; lvl = '0; mp = '0; mo = '0;
      edge_n = 0; rr = 0; cur_id = 0; busy = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin win[i] = '0; seen[i] = 0; end
    end else begin
      pre = mp; prs = '0; gm = '0;
      if (edge_n % DIV == DIV - 1)
        for (int i = 0; i < N; i++) begin
          win[i] = {win[i][STABLE-2:0], d2[i]};
          seen[i]++;
          if (seen[i] >= STABLE && win[i] == {STABLE{~lvl[i]}}) begin
            lvl[i] = ~lvl[i];
            seen[i] = 0;
            prs[i] = lvl[i];
          end
        end
      if (busy) begin
        if (evt.evt_ready) busy = 0;
      end else if (pre != 0) begin
        g = 0;
        for (int k = N - 1; k >= 0; k--) if (pre[ID_W'((rr + k) % N)]) g = (rr + k) % N;
        gm = N'(1) << g;
        exp_q.push_back(g);
        cur_id = g;
        rr = (g + 1) % N;
        busy = 1;
      end
      mo = (clr_overrun ? '0 : mo) | (prs & pre & ~gm);
      mp = (pre & ~gm) | prs;
      d2 = d1;
      d1 = btn_raw;
      edge_n++;
    end
  end
  // monitor: compare outputs every cycle, pop the scoreboard on each handshake
  always @(negedge clk) if (rst) begin
    chk("evt_valid", int'(evt.evt_valid), int'(busy));
    chk("pending", int'(pending), int'(mp));
    chk("overrun", int'(overrun), int'(mo));
    if (evt.evt_valid && busy) chk("held_id", int'(evt.evt_id), cur_id);
    if (evt.evt_valid && evt.evt_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_depth", 0, 1);
      else chk("evt_id", int'(evt.evt_id), exp_q.pop_front());
      n_events++;
    end
  end
  int base, lat;
  int hold [N];
  initial begin
    evt.evt_ready = 0;
    cyc(3);
    chk("rst_valid", int'(evt.evt_valid), 0);
    chk("rst_id", int'(evt.evt_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1;
    evt.evt_ready = 1;
    base = n_events;
    btn_raw[0] = 1;
    lat = 0;
    while (!pending[0] && lat < 20) begin cyc(1); lat++; end
    chk("press_latency_in_window", int'(lat >= 11 && lat <= 14), 1);
    cyc(30);
    btn_raw[0] = 0;
    cyc(40);
    chk("clean_press_events", n_events - base, 1);
    base = n_events;
    for (int s = 0; s < 4; s++) begin btn_raw[1] = ~btn_raw[1]; cyc(5); end
    btn_raw[1] = 1;
    cyc(40);
    btn_raw[1] = 0;
    cyc(30);
    chk("bounce_events", n_events - base, 1);
    rst = 0;
    cyc(2);
    rst = 1;
    base = n_events;
    btn_raw = 4'hF;
    cyc(40);
    btn_raw = 4'h0;
    cyc(30);
    chk("all_four_events", n_events - base, 4);
    base = n_events;
    btn_raw = 4'b0101;
    cyc(40);
    btn_raw = 4'h0;
    cyc(30);
    chk("pair_events", n_events - base, 2);
    evt.evt_ready = 0;
    base = n_events;
    for (int p = 0; p < 3; p++) begin
      btn_raw[2] = 1; cyc(25);
      btn_raw[2] = 0; cyc(25);
    end
    chk("ovr_valid", int'(evt.evt_valid), 1);
    chk("ovr_id", int'(evt.evt_id), 2);
    chk("ovr_pending2", int'(pending[2]), 1);
    chk("ovr_overrun2", int'(overrun[2]), 1);
    clr_overrun = 1; cyc(1); clr_overrun = 0;
    chk("ovr_cleared", int'(overrun), 0);
    evt.evt_ready = 1;
    cyc(10);
    chk("ovr_events", n_events - base, 2);
    evt.evt_ready = 0;
    btn_raw[0] = 1; cyc(25);
    btn_raw[1] = 1; btn_raw[3] = 1; cyc(25);
    chk("pre_rst_valid", int'(evt.evt_valid), 1);
    chk("pre_rst_pending", int'(pending), 4'b1010);
    btn_raw = 4'b1000;
    rst = 0;
    #1;
    chk("async_valid", int'(evt.evt_valid), 0);
    chk("async_id", int'(evt.evt_id), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_overrun", int'(overrun), 0);
    cyc(2);
    rst = 1;
    evt.evt_ready = 1;
    base = n_events;
    cyc(40);
    chk("held_through_reset_events", n_events - base, 1);
    btn_raw = 4'h0;
    cyc(30);
    base = n_events;
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(0, DIV);
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = btn_raw[i] ? $urandom_range(0, DIV - 1) : DIV + $urandom_range(0, DIV);
        end else hold[i]--;
      cyc(1);
    end
    btn_raw = 4'h0;
    cyc(30);
    chk("glitch_events", n_events - base, 0);
    chk("glitch_overrun", int'(overrun), 0);
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(8, 40);
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = $urandom_range(8, 40);
        end else hold[i]--;
      evt.evt_ready = ($urandom % 3) != 0;
      clr_overrun = ($urandom % 50) == 0;
      cyc(1);
    end
    btn_raw = 4'h0;
    clr_overrun = 0;
    evt.evt_ready = 1;
    cyc(80);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_pending", int'(pending), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
